if_fetch_unit: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline. It is the producing end of if_to_id_bus and the consuming end of br_bus, both of which connect to the ID stage. It holds the PC, drives the synchronous-read instruction SRAM so that data returns one cycle later, aligned with ID's registered PC, and applies branch redirects from ID. It also buffers a redirect that arrives while IF is stalled, so the redirect is not lost.

---
 rtl/if_fetch_unit_if.sv | 36 +++
 rtl/if_fetch_unit.sv | 71 +++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
// IF-stage bus bundle: stall vector and branch redirect in, IF->ID bus and
// instruction SRAM port out. The master modport is the fetch unit's view.
interface if_fetch_unit_if #(
    parameter int unsigned STALL_W = 6
);
    localparam int unsigned BR_WD       = 33;
    localparam int unsigned IF_TO_ID_WD = 33;

    logic [STALL_W-1:0]     stall;
    logic [BR_WD-1:0]       br_bus;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;

    modport master (
        input  stall,
        input  br_bus,
        output if_to_id_bus,
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata
    );

    modport slave (
        output stall,
        output br_bus,
        input  if_to_id_bus,
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: PC register, sync-read SRAM addressing, and
// branch redirects from ID, with one buffered redirect held across IF stalls.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_unit_if.master   bus
);
    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic        br_e;
    logic [31:0] br_addr;
    logic        if_stall;
    logic [31:0] next_pc;
    logic        unused_stall;

    assign br_e         = bus.br_bus[32];
    assign br_addr      = bus.br_bus[31:0];
    assign if_stall     = bus.stall[0];
    assign unused_stall = ^bus.stall[$bits(bus.stall)-1:1];

    // A live redirect beats a buffered one; buffered beats sequential.
    always_comb begin
        next_pc = pc_q + PC_STEP;
        if (br_e) begin
            next_pc = br_addr;
        end else if (pend_v_q) begin
            next_pc = pend_addr_q;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        ce_d        = ce_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        if (!if_stall) begin
            pc_d     = next_pc;
            ce_d     = 1'b1;
            pend_v_d = 1'b0;
        end else if (br_e) begin
            pend_v_d    = 1'b1;
            pend_addr_d = br_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC - PC_STEP;
            ce_q        <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign bus.if_to_id_bus    = {ce_q, pc_q};
    assign bus.inst_sram_en    = ce_q;
    assign bus.inst_sram_addr  = pc_q;
    assign bus.inst_sram_wen   = '0;
    assign bus.inst_sram_wdata = '0;
endmodule
